msfsm_vme_arbiter: RTL and testbench

//  Shares one msfsms_mealy VME bus controller between two requesters. Each requester uses a 4-phase
//  req/ack handshake with a read/write select. The block serialises the requests with a round-robin

---
 rtl/msfsm_arb_pkg.sv | 18 +
 rtl/msfsm_vme_arbiter_if.sv | 31 +++
 rtl/rr_arb2.sv | 38 +++
 rtl/msfsm_vme_arbiter.sv | 154 +++++++++++++++
 tb/tb_msfsm_vme_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msfsm_arb_pkg.sv
// Shared types and constants for the two-requester VME controller arbiter.
package msfsm_arb_pkg;

    localparam int unsigned NREQ = 2;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4,
        WAIT_LO = 3'd5
    } arb_state_t;

endpackage

// File: rtl/msfsm_vme_arbiter_if.sv
// Requester handshakes, controller event pulses and status, bundled for the arbiter.
interface msfsm_vme_arbiter_if;
    import msfsm_arb_pkg::*;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] rw;
    logic [NREQ-1:0] ack;
    logic            dsr_PLUS;
    logic            dsr_MINUS;
    logic            dsw_PLUS;
    logic            dsw_MINUS;
    logic            dtack_PLUS;
    logic            dtack_MINUS;
    logic            busy;
    logic            owner;
    logic            err;
    logic            err_clr;

    // Arbiter side.
    modport slave (
        input  req, rw, dtack_PLUS, dtack_MINUS, err_clr,
        output ack, dsr_PLUS, dsr_MINUS, dsw_PLUS, dsw_MINUS, busy, owner, err
    );

    // Requester / controller side.
    modport master (
        output req, rw, dtack_PLUS, dtack_MINUS, err_clr,
        input  ack, dsr_PLUS, dsr_MINUS, dsw_PLUS, dsw_MINUS, busy, owner, err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_arb2
    import msfsm_arb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic            gnt_idx,
    output logic            gnt_vld
);

    // Requester preferred on a tie; 0 out of reset.
    logic prio_q;

    // Combinational pick from the current request vector.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = prio_q;
            default: gnt_idx = 1'b0;
        endcase
    end

    // Hand the tie-break to the other requester whenever a grant is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (en && gnt_vld) begin
            prio_q <= ~gnt_idx;
        end
    end

endmodule

// File: rtl/msfsm_vme_arbiter.sv
// Serialises two 4-phase requesters onto one VME bus controller, turning each
// handshake into dsr/dsw start/release event pulses and closing it on the
// controller's dtack events, with a sticky error for timeouts and stray events.
module msfsm_vme_arbiter
    import msfsm_arb_pkg::*;
#(
    parameter int unsigned TO_W     = 8,
    parameter int unsigned TO_LIMIT = 200
)(
    input  logic                clk,
    input  logic                reset,
    msfsm_vme_arbiter_if.slave  bus
);

    localparam logic [TO_W-1:0] TO_MAX = '1;
    localparam logic [TO_W-1:0] TO_HIT = TO_W'(TO_LIMIT);

    arb_state_t       state_q;
    logic             owner_q;
    logic             rw_q;
    logic [NREQ-1:0]  ack_q;
    logic             dsr_plus_q;
    logic             dsr_minus_q;
    logic             dsw_plus_q;
    logic             dsw_minus_q;
    logic             busy_q;
    logic             err_q;
    logic [TO_W-1:0]  to_cnt_q;

    logic             gnt_idx;
    logic             gnt_vld;
    logic [TO_W-1:0]  to_cnt_inc;
    logic             waiting;
    logic             to_hit;
    logic             spurious;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req),
        .en      (state_q == IDLE),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Watchdog and stray-event detection feeding the sticky error.
    always_comb begin
        to_cnt_inc = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);
        waiting    = ((state_q == WAIT_HI) && !bus.dtack_PLUS) ||
                     ((state_q == WAIT_LO) && !bus.dtack_MINUS);
        to_hit     = waiting && (to_cnt_inc == TO_HIT) && (to_cnt_q != TO_HIT);
        spurious   = (bus.dtack_PLUS  && !((state_q == ISSUE)   || (state_q == WAIT_HI))) ||
                     (bus.dtack_MINUS && !((state_q == RELEASE) || (state_q == WAIT_LO)));
    end

    // Transaction FSM with registered pulses, ack, busy, owner and error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rw_q        <= RW_READ;
            ack_q       <= '0;
            dsr_plus_q  <= 1'b0;
            dsr_minus_q <= 1'b0;
            dsw_plus_q  <= 1'b0;
            dsw_minus_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            dsr_plus_q  <= 1'b0;
            dsr_minus_q <= 1'b0;
            dsw_plus_q  <= 1'b0;
            dsw_minus_q <= 1'b0;

            if (bus.err_clr) begin
                err_q <= 1'b0;
            end else if (spurious || to_hit) begin
                err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        state_q    <= ISSUE;
                        owner_q    <= gnt_idx;
                        rw_q       <= bus.rw[gnt_idx];
                        busy_q     <= 1'b1;
                        dsw_plus_q <= (bus.rw[gnt_idx] == RW_WRITE);
                        dsr_plus_q <= (bus.rw[gnt_idx] == RW_READ);
                    end
                end
                // A Mealy controller may answer within the start-pulse cycle.
                ISSUE: begin
                    if (bus.dtack_PLUS) begin
                        ack_q[owner_q] <= 1'b1;
                        state_q        <= HOLD;
                    end else begin
                        state_q  <= WAIT_HI;
                        to_cnt_q <= '0;
                    end
                end
                WAIT_HI: begin
                    if (bus.dtack_PLUS) begin
                        ack_q[owner_q] <= 1'b1;
                        state_q        <= HOLD;
                    end else begin
                        to_cnt_q <= to_cnt_inc;
                    end
                end
                HOLD: begin
                    if (!bus.req[owner_q]) begin
                        ack_q[owner_q] <= 1'b0;
                        state_q        <= RELEASE;
                        dsw_minus_q    <= (rw_q == RW_WRITE);
                        dsr_minus_q    <= (rw_q == RW_READ);
                    end
                end
                // Likewise the release may be answered within its pulse cycle.
                RELEASE: begin
                    if (bus.dtack_MINUS) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q  <= WAIT_LO;
                        to_cnt_q <= '0;
                    end
                end
                WAIT_LO: begin
                    if (bus.dtack_MINUS) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.dsr_PLUS  = dsr_plus_q;
    assign bus.dsr_MINUS = dsr_minus_q;
    assign bus.dsw_PLUS  = dsw_plus_q;
    assign bus.dsw_MINUS = dsw_minus_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_msfsm_vme_arbiter.sv
// Scoreboard bench: stimulus pushes the expected grant order, a monitor pops and
// compares on every controller event pulse, and a reactive controller model answers.
`timescale 1ns/1ps
module tb_msfsm_vme_arbiter;
    import msfsm_arb_pkg::*;

    localparam int unsigned TO_LIMIT = 200;

    typedef struct packed {
        logic owner;
        logic wr;
    } txn_t;

    logic clk;
    logic reset;
    msfsm_vme_arbiter_if bus();

    msfsm_vme_arbiter #(.TO_W(8), .TO_LIMIT(TO_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    txn_t exp_plus[$];
    txn_t exp_minus[$];
    logic pref = 1'b0;
    bit   ctl_hold_plus = 1'b0;
    int   spur_req = 0;
    int   spur_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference grant model: lone request wins, tie goes to the one not served last.
    task automatic expect_grant(input logic o, input logic wr);
        txn_t t;
        t = '{owner: o, wr: wr};
        exp_plus.push_back(t);
        exp_minus.push_back(t);
        pref = ~o;
    endtask

    // Monitor: pop and compare whenever the DUT emits an event pulse or ack.
    initial begin
        logic [1:0] pv;
        logic [1:0] mv;
        logic       cur_owner;
        txn_t       t;
        cur_owner = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pv = {bus.dsw_PLUS, bus.dsr_PLUS};
                mv = {bus.dsw_MINUS, bus.dsr_MINUS};
                if (pv != 2'b00) begin
                    if (exp_plus.size() == 0) begin
                        check("plus_unexpected", 32'(pv), 32'(0));
                    end else begin
                        t = exp_plus.pop_front();
                        cur_owner = t.owner;
                        check("plus_kind", 32'(pv), 32'(t.wr ? 2'b10 : 2'b01));
                        check("plus_owner", 32'(bus.owner), 32'(t.owner));
                        check("plus_busy", 32'(bus.busy), 32'(1));
                    end
                end
                if (mv != 2'b00) begin
                    if (exp_minus.size() == 0) begin
                        check("minus_unexpected", 32'(mv), 32'(0));
                    end else begin
                        t = exp_minus.pop_front();
                        check("minus_kind", 32'(mv), 32'(t.wr ? 2'b10 : 2'b01));
                        check("minus_owner", 32'(bus.owner), 32'(t.owner));
                    end
                end
                if (bus.ack != 2'b00) begin
                    check("ack_owner", 32'(bus.ack), 32'(2'(2'b01 << cur_owner)));
                end
            end
        end
    end

    // Controller model: answers start/release pulses with dtack events after a random delay.
    initial begin
        int p_cnt;
        int m_cnt;
        bit owed;
        p_cnt = 0;
        m_cnt = 0;
        owed  = 1'b0;
        bus.dtack_PLUS  = 1'b0;
        bus.dtack_MINUS = 1'b0;
        forever begin
            @(negedge clk);
            bus.dtack_PLUS  = 1'b0;
            bus.dtack_MINUS = 1'b0;
            if (reset || !bus.busy) begin
                p_cnt = 0;
                m_cnt = 0;
                owed  = 1'b0;
            end else begin
                if (p_cnt > 0) begin
                    p_cnt--;
                    if (p_cnt == 0) bus.dtack_PLUS = 1'b1;
                end
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) bus.dtack_MINUS = 1'b1;
                end
                if (owed && !ctl_hold_plus) begin
                    owed = 1'b0;
                    bus.dtack_PLUS = 1'b1;
                end
                if (bus.dsr_PLUS || bus.dsw_PLUS) begin
                    if (ctl_hold_plus) owed = 1'b1;
                    else p_cnt = $urandom_range(1, 4);
                end
                if (bus.dsr_MINUS || bus.dsw_MINUS) m_cnt = $urandom_range(1, 3);
            end
            if (spur_done != spur_req) begin
                spur_done = spur_req;
                bus.dtack_MINUS = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("wait_idle_timeout", 32'(bus.busy), 32'(0));
    endtask

    task automatic wait_pulse();
        int n;
        n = 0;
        while (!(bus.dsr_PLUS || bus.dsw_PLUS) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.dsr_PLUS || bus.dsw_PLUS)) check("start_pulse_timeout", 32'(0), 32'(1));
    endtask

    // One requester's 4-phase handshake, optionally withdrawing before ack.
    task automatic requester(input logic idx, input bit early, input int hold);
        int n;
        n = 0;
        while (!(bus.busy && bus.owner == idx) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.busy && bus.owner == idx)) check("grant_timeout", 32'(0), 32'(1));
        if (early) bus.req[idx] = 1'b0;
        n = 0;
        while (!bus.ack[idx] && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("ack_rise", 32'(bus.ack[idx]), 32'(1));
        if (!early) begin
            bus.rw[idx] = 1'($urandom);
            repeat (hold) @(negedge clk);
            bus.req[idx] = 1'b0;
        end
        @(negedge clk);
        check("ack_fall", 32'(bus.ack[idx]), 32'(0));
    endtask

    task automatic do_round(input logic [1:0] pat, input logic [1:0] rwv,
                            input logic [1:0] early, input int h0, input int h1);
        logic first;
        wait_idle();
        if (pat == 2'b11) begin
            first = pref;
            expect_grant(first, rwv[first]);
            expect_grant(~first, rwv[~first]);
        end else begin
            first = pat[1];
            expect_grant(first, rwv[first]);
        end
        bus.rw  = rwv;
        bus.req = pat;
        fork
            if (pat[0]) requester(1'b0, early[0], h0);
            if (pat[1]) requester(1'b1, early[1], h1);
        join
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},    32'(bus.ack),   32'(0));
        check({tag, "_busy"},   32'(bus.busy),  32'(0));
        check({tag, "_owner"},  32'(bus.owner), 32'(0));
        check({tag, "_err"},    32'(bus.err),   32'(0));
        check({tag, "_pulses"}, 32'({bus.dsr_PLUS, bus.dsr_MINUS, bus.dsw_PLUS, bus.dsw_MINUS}), 32'(0));
    endtask

    initial begin
        reset       = 1'b1;
        bus.req     = 2'b00;
        bus.rw      = 2'b00;
        bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Single read from requester 0.
        do_round(2'b01, 2'b00, 2'b00, 2, 0);
        check("read_done_busy", 32'(bus.busy), 32'(0));

        // Stray dtack_MINUS while idle.
        check("err_before_spur", 32'(bus.err), 32'(0));
        spur_req++;
        while (spur_done != spur_req) @(negedge clk);
        @(negedge clk);
        check("spur_err", 32'(bus.err), 32'(1));
        check("spur_busy", 32'(bus.busy), 32'(0));
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("spur_err_clr", 32'(bus.err), 32'(0));

        // Write from requester 1, rw toggled after grant.
        do_round(2'b10, 2'b10, 2'b00, 1, 0);
        do_round(2'b01, 2'b01, 2'b01, 0, 0);

        // Timeout: withhold dtack_PLUS.
        wait_idle();
        ctl_hold_plus = 1'b1;
        expect_grant(1'b0, RW_READ);
        bus.rw  = 2'b00;
        bus.req = 2'b01;
        wait_pulse();
        repeat (TO_LIMIT) @(posedge clk);
        @(negedge clk);
        check("to_err_before_limit", 32'(bus.err), 32'(0));
        @(negedge clk);
        check("to_err_at_limit", 32'(bus.err), 32'(1));
        check("to_still_busy", 32'(bus.busy), 32'(1));
        ctl_hold_plus = 1'b0;
        requester(1'b0, 1'b0, 1);
        wait_idle();
        check("to_err_sticky", 32'(bus.err), 32'(1));
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("to_err_clr", 32'(bus.err), 32'(0));

        // Reset while waiting for dtack_PLUS.
        ctl_hold_plus = 1'b1;
        expect_grant(1'b1, RW_WRITE);
        bus.rw  = 2'b10;
        bus.req = 2'b10;
        wait_pulse();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        exp_minus.delete();
        pref = 1'b0;
        ctl_hold_plus = 1'b0;
        check_all_zero("midreset");

        // Contention from reset: 0 first, then 1, then 0 again.
        do_round(2'b11, 2'b00, 2'b00, 1, 2);
        do_round(2'b11, 2'b11, 2'b00, 0, 1);

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            logic [1:0] pat;
            logic [1:0] ea;
            pat = 2'($urandom_range(1, 3));
            ea  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            do_round(pat, 2'($urandom), ea, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (4) @(negedge clk);
        check("end_plus_queue", 32'(exp_plus.size()), 32'(0));
        check("end_minus_queue", 32'(exp_minus.size()), 32'(0));
        check("end_err", 32'(bus.err), 32'(0));
        check("end_busy", 32'(bus.busy), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
